// File: rtl/control_seq_if.sv
// -----------------------------------------------------------------------------
// control_seq_if
//
// Purpose:
//   Bundles the instruction fields, the ALU flags and every control strobe /
//   mux select exchanged between the multi-cycle datapath and the control
//   sequencer (control_seq).
//
// Signals:
//   opcode[5:0], funct[5:0]  instruction register fields   (datapath -> ctrl)
//   zero, overflow           ALU flags, combinational       (datapath -> ctrl)
//   alusrca                  ALU A select: 0=PC, 1=A        (ctrl -> datapath)
//   alusrcb[1:0]             ALU B select: 0=rt, 1=4, 2=SE, 3=SE<<2
//   aluop[2:0]               000=ADD, 001=SUB, 010=FUNCT
//   pc_write, pc_write_cond, iord, mem_write, ir_write,
//   reg_write, reg_dst, mem_to_reg, epc_write   1-bit strobes
//   pc_source[1:0]           0=ALU, 1=ALUOut, 2=jump, 3=exception vector
//   state_out[3:0]           current sequencer state code
//
// Modports:
//   master : datapath side (drives instruction fields and flags)
//   slave  : control sequencer side (drives strobes and selects)
// -----------------------------------------------------------------------------
interface control_seq_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;

    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       epc_write;
    logic [1:0] pc_source;
    logic [3:0] state_out;

    modport master (
        output opcode,
        output funct,
        output zero,
        output overflow,
        input  alusrca,
        input  alusrcb,
        input  aluop,
        input  pc_write,
        input  pc_write_cond,
        input  iord,
        input  mem_write,
        input  ir_write,
        input  reg_write,
        input  reg_dst,
        input  mem_to_reg,
        input  epc_write,
        input  pc_source,
        input  state_out
    );

    modport slave (
        input  opcode,
        input  funct,
        input  zero,
        input  overflow,
        output alusrca,
        output alusrcb,
        output aluop,
        output pc_write,
        output pc_write_cond,
        output iord,
        output mem_write,
        output ir_write,
        output reg_write,
        output reg_dst,
        output mem_to_reg,
        output epc_write,
        output pc_source,
        output state_out
    );

endinterface

// File: rtl/control_seq.sv
// -----------------------------------------------------------------------------
// control_seq
//
// Purpose:
//   Multi-cycle MIPS-style control sequencer. A Moore FSM walks each
//   instruction through FETCH / DECODE / execute / memory / write-back states
//   and drives the datapath strobes and mux selects from the current state and
//   a small memory wait counter.
//
// Parameters:
//   MEM_LATENCY  cycles per memory access (legal range 1..7, default 2)
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   reset  asynchronous, active-low; while low the FSM sits in FETCH with the
//          wait counter cleared and every output (including selects) is 0
//   bus    control_seq_if.slave: instruction fields and ALU flags in,
//          control strobes, mux selects and state_out out
//
// Optional feature:
//   OVERFLOW_TRAP_EN  when defined, an ALU overflow during EXEC_R (add/sub
//                     funct codes) or EXEC_I diverts to the EXC state instead
//                     of the write-back state, so no register write happens.
//                     When undefined, overflow is ignored.
//
// State codes: FETCH=0 DECODE=1 EXEC_R=2 WB_R=3 EXEC_I=4 WB_I=5 MEM_ADDR=6
//              MEM_RD=7 WB_MEM=8 MEM_WR=9 BRANCH=10 JUMP=11 EXC=12;
//              codes 13..15 recover to FETCH with all strobes low.
// -----------------------------------------------------------------------------
module control_seq #(
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    control_seq_if.slave  bus
);

    // ---------------------------------------------------------------------
    // State codes
    // ---------------------------------------------------------------------
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_WB_R     = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_WB_I     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_EXC      = 4'd12;

    // ---------------------------------------------------------------------
    // Instruction decode constants
    // ---------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

`ifdef OVERFLOW_TRAP_EN
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
`endif

    // ALU operation and mux-select encodings
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_SE   = 2'd2;
    localparam logic [1:0] SRCB_SESH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_EXC    = 2'd3;

    // Counter value on the final cycle of a memory access.
    localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

    // ---------------------------------------------------------------------
    // State and wait counter
    // ---------------------------------------------------------------------
    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [2:0] cnt_reg;
    logic [2:0] cnt_next;

    logic is_mem_state;
    logic mem_last;

    // FETCH, MEM_RD and MEM_WR are the states that wait on memory.
    assign is_mem_state = (state_reg == S_FETCH) ||
                          (state_reg == S_MEM_RD) ||
                          (state_reg == S_MEM_WR);

    // '>=' rather than '==' so an out-of-range count can never stall a state.
    assign mem_last = is_mem_state && (cnt_reg >= LAST_CNT);

`ifdef OVERFLOW_TRAP_EN
    // Only add/sub can overflow among the R-type operations.
    logic r_overflow;
    assign r_overflow = bus.overflow &&
                        ((bus.funct == FUNCT_ADD) || (bus.funct == FUNCT_SUB));

    // zero is consumed by the datapath (pc_write_cond AND zero), not here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.zero};
`else
    // Without the trap, overflow and funct have no effect on sequencing;
    // zero is always consumed datapath-side.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.zero, bus.overflow, bus.funct};
`endif

    // ---------------------------------------------------------------------
    // Process 1: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Process 2: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH: begin
                state_next = mem_last ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_next = S_EXEC_R;
                    OP_ADDI:       state_next = S_EXEC_I;
                    OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    default:       state_next = S_EXC;
                endcase
            end
            S_EXEC_R: begin
`ifdef OVERFLOW_TRAP_EN
                state_next = r_overflow ? S_EXC : S_WB_R;
`else
                state_next = S_WB_R;
`endif
            end
            S_WB_R: begin
                state_next = S_FETCH;
            end
            S_EXEC_I: begin
`ifdef OVERFLOW_TRAP_EN
                state_next = bus.overflow ? S_EXC : S_WB_I;
`else
                state_next = S_WB_I;
`endif
            end
            S_WB_I: begin
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                // Only lw and sw reach here; anything other than lw is a store.
                state_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                state_next = mem_last ? S_WB_MEM : S_MEM_RD;
            end
            S_WB_MEM: begin
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                state_next = mem_last ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                state_next = S_FETCH;
            end
            S_JUMP: begin
                state_next = S_FETCH;
            end
            S_EXC: begin
                state_next = S_FETCH;
            end
            default: begin
                // Unused codes 13..15 recover to FETCH.
                state_next = S_FETCH;
            end
        endcase
    end

    // Wait counter: counts up inside a memory state and is zero whenever a
    // state is entered. Every memory state exits exactly on its last count,
    // so the counter saturates at LAST_CNT and never wraps.
    always_comb begin
        cnt_next = 3'd0;
        if (is_mem_state && !mem_last) begin
            cnt_next = cnt_reg + 3'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Process 3: Moore output logic
    // ---------------------------------------------------------------------
    // Outputs are additionally qualified by reset so that an asynchronous
    // reset in the middle of a write or fetch drops the strobes within the
    // same cycle, independent of what the state register is showing.
    always_comb begin
        bus.alusrca       = 1'b0;
        bus.alusrcb       = SRCB_RT;
        bus.aluop         = ALU_ADD;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.epc_write     = 1'b0;
        bus.pc_source     = PCS_ALU;
        bus.state_out     = 4'd0;

        if (reset) begin
            bus.state_out = state_reg;
            case (state_reg)
                S_FETCH: begin
                    // iord stays 0 (instruction address is the PC). The IR
                    // load and PC+4 update happen only on the final cycle so
                    // the IR captures settled memory data.
                    if (mem_last) begin
                        bus.ir_write  = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alusrca   = 1'b0;
                        bus.alusrcb   = SRCB_FOUR;
                        bus.aluop     = ALU_ADD;
                        bus.pc_source = PCS_ALU;
                    end
                end
                S_DECODE: begin
                    // Precompute the branch target PC + (SE<<2).
                    bus.alusrca = 1'b0;
                    bus.alusrcb = SRCB_SESH;
                    bus.aluop   = ALU_ADD;
                end
                S_EXEC_R: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = SRCB_RT;
                    bus.aluop   = ALU_FUNCT;
                end
                S_WB_R: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 1'b1;
                    bus.mem_to_reg = 1'b0;
                end
                S_EXEC_I: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = SRCB_SE;
                    bus.aluop   = ALU_ADD;
                end
                S_WB_I: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b0;
                end
                S_MEM_ADDR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = SRCB_SE;
                    bus.aluop   = ALU_ADD;
                end
                S_MEM_RD: begin
                    bus.iord = 1'b1;
                end
                S_WB_MEM: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 1'b0;
                    bus.mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                end
                S_BRANCH: begin
                    // Compare rs - rt; the datapath gates the PC load with zero.
                    bus.alusrca       = 1'b1;
                    bus.alusrcb       = SRCB_RT;
                    bus.aluop         = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = PCS_ALUOUT;
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCS_JUMP;
                end
                S_EXC: begin
                    bus.epc_write = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCS_EXC;
                end
                default: begin
                    // Codes 13..15: all strobes stay low.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// -----------------------------------------------------------------------------
// tb_control_seq
//
// Directed, self-checking bench for control_seq. Each instruction pushes its
// expected per-cycle control word (state code plus every strobe and select)
// into a queue; the queue is then drained one clock at a time, comparing the
// DUT's outputs against the popped entry.
// -----------------------------------------------------------------------------
module tb_control_seq;

    localparam int ML = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    control_seq_if bus ();

    control_seq #(
        .MEM_LATENCY (ML)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [20:0] exp_q [$];
    string       tag;

    // Expected control word for a state:
    // {state[3:0], alusrca, alusrcb[1:0], aluop[2:0], pc_write, pc_write_cond,
    //  iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, epc_write,
    //  pc_source[1:0]}
    function automatic logic [20:0] exp_ctl(input int st, input bit last);
        logic       a;
        logic [1:0] b;
        logic [2:0] op;
        logic       pcw, pcwc, iord, mw, irw, rw, rd, m2r, epc;
        logic [1:0] pcs;
        a = 0; b = 0; op = 0; pcw = 0; pcwc = 0; iord = 0; mw = 0;
        irw = 0; rw = 0; rd = 0; m2r = 0; epc = 0; pcs = 0;
        case (st)
            0:  if (last) begin irw = 1; pcw = 1; b = 2'd1; end
            1:  b = 2'd3;
            2:  begin a = 1; op = 3'b010; end
            3:  begin rw = 1; rd = 1; end
            4:  begin a = 1; b = 2'd2; end
            5:  rw = 1;
            6:  begin a = 1; b = 2'd2; end
            7:  iord = 1;
            8:  begin rw = 1; m2r = 1; end
            9:  begin iord = 1; mw = 1; end
            10: begin a = 1; op = 3'b001; pcwc = 1; pcs = 2'd1; end
            11: begin pcw = 1; pcs = 2'd2; end
            12: begin epc = 1; pcw = 1; pcs = 2'd3; end
            default: ;
        endcase
        return {4'(st), a, b, op, pcw, pcwc, iord, mw, irw, rw, rd, m2r, epc, pcs};
    endfunction

    function automatic logic [20:0] obs_ctl();
        return {bus.state_out, bus.alusrca, bus.alusrcb, bus.aluop,
                bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.epc_write, bus.pc_source};
    endfunction

    task automatic check(input logic [20:0] e, input string name);
        logic [20:0] o;
        o = obs_ctl();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, o, e);
        end
    endtask

    task automatic push(input int st);
        exp_q.push_back(exp_ctl(st, 1'b0));
    endtask

    // Memory states occupy ML cycles; only the last one is flagged.
    task automatic push_mem(input int st);
        for (int i = 0; i < ML; i++) begin
            exp_q.push_back(exp_ctl(st, i == ML - 1));
        end
    endtask

    // Pop one expected word per clock, sampling mid-cycle (after the
    // negative edge) so outputs are settled well away from the rising edge.
    task automatic drain();
        int          n;
        logic [20:0] e;
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            check(e, $sformatf("%s[%0d]", tag, n));
            n++;
            @(negedge clk);
        end
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic z);
        bus.opcode   = op;
        bus.funct    = fn;
        bus.overflow = ovf;
        bus.zero     = z;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        set_instr(6'h00, 6'h20, 1'b0, 1'b0);

        // Reset holds everything at zero, across rising edges too.
        @(negedge clk);
        #1;
        check(21'd0, "reset_zero");
        @(negedge clk);
        #1;
        check(21'd0, "reset_hold");

        // Release mid-cycle; the following cycle is FETCH cycle 1.
        @(negedge clk);
        reset = 1'b1;

        // add: 0,0,1,2,3
        tag = "add";
        set_instr(6'h00, 6'h20, 1'b0, 1'b0);
        push_mem(0); push(1); push(2); push(3);
        drain();

        // add with overflow
        tag = "add_ovf";
        set_instr(6'h00, 6'h20, 1'b1, 1'b0);
        push_mem(0); push(1); push(2);
`ifdef OVERFLOW_TRAP_EN
        push(12);
`else
        push(3);
`endif
        drain();

        // R-type that cannot overflow (and): overflow never traps
        tag = "and_ovf";
        set_instr(6'h00, 6'h24, 1'b1, 1'b0);
        push_mem(0); push(1); push(2); push(3);
        drain();

        // lw: 0,0,1,6,7,7,8
        tag = "lw";
        set_instr(6'h23, 6'h00, 1'b0, 1'b0);
        push_mem(0); push(1); push(6); push_mem(7); push(8);
        drain();

        // sw
        tag = "sw";
        set_instr(6'h2B, 6'h00, 1'b0, 1'b0);
        push_mem(0); push(1); push(6); push_mem(9);
        drain();

        // beq with zero=1
        tag = "beq";
        set_instr(6'h04, 6'h00, 1'b0, 1'b1);
        push_mem(0); push(1); push(10);
        drain();

        // j
        tag = "j";
        set_instr(6'h02, 6'h00, 1'b0, 1'b0);
        push_mem(0); push(1); push(11);
        drain();

        // addi, no overflow
        tag = "addi";
        set_instr(6'h08, 6'h00, 1'b0, 1'b0);
        push_mem(0); push(1); push(4); push(5);
        drain();

        // addi with overflow
        tag = "addi_ovf";
        set_instr(6'h08, 6'h00, 1'b1, 1'b0);
        push_mem(0); push(1); push(4);
`ifdef OVERFLOW_TRAP_EN
        push(12);
`else
        push(5);
`endif
        drain();

        // illegal opcode
        tag = "illegal";
        set_instr(6'h3F, 6'h00, 1'b0, 1'b0);
        push_mem(0); push(1); push(12);
        drain();

        // sw interrupted by reset in the first MEM_WR cycle
        tag = "sw_rst";
        set_instr(6'h2B, 6'h00, 1'b0, 1'b0);
        push_mem(0); push(1); push(6);
        drain();
        #1;
        check(exp_ctl(9, ML == 1), "sw_rst_mw1");
        reset = 1'b0;
        #1;
        check(21'd0, "sw_rst_drop");
        @(negedge clk);
        #1;
        check(21'd0, "sw_rst_hold");
        reset = 1'b1;

        // Recovery: first cycle after release is FETCH cycle 1 (iord=0).
        tag = "post_rst_add";
        set_instr(6'h00, 6'h22, 1'b0, 1'b0);
        push_mem(0); push(1); push(2); push(3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
